// File: rtl/rn_free_list.sv
// rn_free_list: physical-register free list feeding the 4-wide rename stage (optional RN_FL_OVF_CHK_EN).
// Latency: allocation read is combinational (0 cycles); freed registers become allocatable next cycle.
// Backpressure: alloc_stall_o holds the whole rename group while free entries < requested destinations.
module rn_free_list #(
    parameter int PREG_NUM = 64,
    parameter int ARCH_NUM = 32,
    parameter int PREG_W   = 6,
    parameter int FL_DEPTH = PREG_NUM - ARCH_NUM,
    parameter int PTR_W    = $clog2(FL_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alloc_vld_i,
    input  logic              inst0_ard_vld_i,
    input  logic              inst1_ard_vld_i,
    input  logic              inst2_ard_vld_i,
    input  logic              inst3_ard_vld_i,
    output logic [PREG_W-1:0] inst0_prd_o,
    output logic [PREG_W-1:0] inst1_prd_o,
    output logic [PREG_W-1:0] inst2_prd_o,
    output logic [PREG_W-1:0] inst3_prd_o,
    output logic              alloc_stall_o,
    input  logic              free0_vld_i,
    input  logic              free1_vld_i,
    input  logic              free2_vld_i,
    input  logic              free3_vld_i,
    input  logic [PREG_W-1:0] free0_prd_i,
    input  logic [PREG_W-1:0] free1_prd_i,
    input  logic [PREG_W-1:0] free2_prd_i,
    input  logic [PREG_W-1:0] free3_prd_i,
    input  logic [2:0]        cmt_num_i,
    input  logic              flush_i,
    output logic [PTR_W-1:0]  fl_cnt_o,
    output logic              fl_err_o
);
    localparam int IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(FL_DEPTH);

    logic [PREG_W-1:0] entry [FL_DEPTH];
    logic [PTR_W-1:0]  head, cmt_head, tail;

    logic [3:0]        ard_vld, free_vld;
    logic [PREG_W-1:0] free_prd [4];
    logic [PTR_W-1:0]  off [4];
    logic [PTR_W-1:0]  foff [4];
    logic [IDX_W-1:0]  rd_idx [4];
    logic [IDX_W-1:0]  wr_idx [4];
    logic [PTR_W-1:0]  req, nfree, cnt;
    logic [PTR_W-1:0]  cmt_head_nxt, tail_nxt, head_alloc, head_nxt;
    logic              stall, fire;

    assign ard_vld  = {inst3_ard_vld_i, inst2_ard_vld_i, inst1_ard_vld_i, inst0_ard_vld_i};
    assign free_vld = {free3_vld_i, free2_vld_i, free1_vld_i, free0_vld_i};
    assign free_prd[0] = free0_prd_i;
    assign free_prd[1] = free1_prd_i;
    assign free_prd[2] = free2_prd_i;
    assign free_prd[3] = free3_prd_i;

    // Prefix counts: read offset per renaming lane, compacted write slot per free lane.
    always_comb begin
        off[0]  = '0;
        foff[0] = '0;
        for (int k = 1; k < 4; k++) begin
            off[k]  = off[k-1]  + PTR_W'(ard_vld[k-1]);
            foff[k] = foff[k-1] + PTR_W'(free_vld[k-1]);
        end
        req   = off[3]  + PTR_W'(ard_vld[3]);
        nfree = foff[3] + PTR_W'(free_vld[3]);
        for (int k = 0; k < 4; k++) begin
            rd_idx[k] = IDX_W'(head + off[k]);
            wr_idx[k] = IDX_W'(tail + foff[k]);
        end
    end

    // Occupancy, all-or-nothing stall, and next pointer values (flush overrides allocation).
    always_comb begin
        cnt          = tail - head;
        stall        = alloc_vld_i & (req > cnt);
        fire         = alloc_vld_i & ~stall & ~flush_i;
        cmt_head_nxt = cmt_head + PTR_W'(cmt_num_i);
        tail_nxt     = tail + nfree;
        head_alloc   = fire ? head + req : head;
        head_nxt     = flush_i ? cmt_head_nxt : head_alloc;
    end

    assign inst0_prd_o   = entry[rd_idx[0]];
    assign inst1_prd_o   = entry[rd_idx[1]];
    assign inst2_prd_o   = entry[rd_idx[2]];
    assign inst3_prd_o   = entry[rd_idx[3]];
    assign alloc_stall_o = stall;
    assign fl_cnt_o      = cnt;

    // Pointer registers; the list starts full with tail one lap ahead of head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head     <= '0;
            cmt_head <= '0;
            tail     <= DEPTH_P;
        end else begin
            head     <= head_nxt;
            cmt_head <= cmt_head_nxt;
            tail     <= tail_nxt;
        end
    end

    // Entry storage: reset to the non-architectural pregs, then compacted frees land at tail.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry[i] <= PREG_W'(ARCH_NUM + i);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (free_vld[k]) begin
                    entry[wr_idx[k]] <= free_prd[k];
                end
            end
        end
    end

`ifdef RN_FL_OVF_CHK_EN
    logic [PTR_W-1:0] cnt_nxt, cmt_gap;
    logic             err;

    // Overflow if the next count exceeds capacity; commit overrun if cmt_head goes beyond head.
    always_comb begin
        cnt_nxt = tail_nxt - head_nxt;
        cmt_gap = head_alloc - cmt_head_nxt;
    end

    // Sticky error; the offending update is still applied.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if ((cnt_nxt > DEPTH_P) || (cmt_gap > DEPTH_P)) begin
            err <= 1'b1;
        end
    end

    assign fl_err_o = err;
`else
    assign fl_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rn_free_list.sv
// tb_rn_free_list: directed stimulus for rn_free_list with a queue-based reference model.
// The model tracks free registers in order (avail) and allocated-uncommitted ones (spec).
// A negedge process compares every output against the model each cycle.
module tb_rn_free_list;
    logic       clk;
    logic       rst;
    logic       alloc_vld;
    logic [3:0] ard;
    logic [5:0] prd [4];
    logic       alloc_stall;
    logic [3:0] fv;
    logic [5:0] fprd [4];
    logic [2:0] cmt;
    logic       flush;
    logic [5:0] fl_cnt;
    logic       fl_err;

    int checks = 0;
    int passes = 0;

    logic [5:0] avail [$];
    logic [5:0] spec [$];
    bit         merr;
    int         m_req, m_off, m_nfree;
    bit         m_fire;

    rn_free_list dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .alloc_vld_i     (alloc_vld),
        .inst0_ard_vld_i (ard[0]),
        .inst1_ard_vld_i (ard[1]),
        .inst2_ard_vld_i (ard[2]),
        .inst3_ard_vld_i (ard[3]),
        .inst0_prd_o     (prd[0]),
        .inst1_prd_o     (prd[1]),
        .inst2_prd_o     (prd[2]),
        .inst3_prd_o     (prd[3]),
        .alloc_stall_o   (alloc_stall),
        .free0_vld_i     (fv[0]),
        .free1_vld_i     (fv[1]),
        .free2_vld_i     (fv[2]),
        .free3_vld_i     (fv[3]),
        .free0_prd_i     (fprd[0]),
        .free1_prd_i     (fprd[1]),
        .free2_prd_i     (fprd[2]),
        .free3_prd_i     (fprd[3]),
        .cmt_num_i       (cmt),
        .flush_i         (flush),
        .fl_cnt_o        (fl_cnt),
        .fl_err_o        (fl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        avail.delete();
        spec.delete();
        for (int i = 0; i < 32; i++) avail.push_back(6'(32 + i));
        merr = 1'b0;
    endtask

    // Per-cycle compare, then advance the model by the edge that follows.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            m_req = 0;
            for (int k = 0; k < 4; k++) m_req += int'(ard[k]);
            chk("fl_cnt", int'(fl_cnt), avail.size());
            chk("alloc_stall", int'(alloc_stall), int'(alloc_vld && (m_req > avail.size())));
            chk("fl_err", int'(fl_err), int'(merr));
            m_off = 0;
            for (int k = 0; k < 4; k++) begin
                if (ard[k]) begin
                    if (m_off < avail.size()) chk($sformatf("prd%0d", k), int'(prd[k]), int'(avail[m_off]));
                    m_off++;
                end
            end
            m_fire = alloc_vld && !flush && (m_req <= avail.size());
            if (m_fire) repeat (m_req) spec.push_back(avail.pop_front());
            if (int'(cmt) > spec.size()) begin
`ifdef RN_FL_OVF_CHK_EN
                merr = 1'b1;
`endif
            end
            repeat (int'(cmt)) if (spec.size() > 0) void'(spec.pop_front());
            if (flush) begin
                avail = {spec, avail};
                spec.delete();
            end
            m_nfree = 0;
            for (int k = 0; k < 4; k++) begin
                if (fv[k]) begin
                    avail.push_back(fprd[k]);
                    m_nfree++;
                end
            end
            if (avail.size() > 32) begin
`ifdef RN_FL_OVF_CHK_EN
                merr = 1'b1;
`endif
            end
        end
    end

    task automatic idle();
        alloc_vld = 1'b0;
        ard       = 4'b0000;
        fv        = 4'b0000;
        cmt       = 3'd0;
        flush     = 1'b0;
        for (int k = 0; k < 4; k++) fprd[k] = 6'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;

        // Reset state: full list offering 32..35.
        ard = 4'b1111;
        #1;
        chk("rst_prd0", int'(prd[0]), 32);
        chk("rst_prd1", int'(prd[1]), 33);
        chk("rst_prd2", int'(prd[2]), 34);
        chk("rst_prd3", int'(prd[3]), 35);
        chk("rst_cnt", int'(fl_cnt), 32);
        chk("rst_stall", int'(alloc_stall), 0);

        // Sparse group 1,0,1,1.
        alloc_vld = 1'b1;
        ard = 4'b1101;
        #1;
        chk("grp_prd0", int'(prd[0]), 32);
        chk("grp_prd2", int'(prd[2]), 33);
        chk("grp_prd3", int'(prd[3]), 34);
        tick();
        idle();
        #1;
        chk("grp_cnt", int'(fl_cnt), 29);

        // Drain to 3, stall a 4-group while freeing preg 7.
        alloc_vld = 1'b1;
        ard = 4'b1111;
        repeat (6) tick();
        ard = 4'b0011;
        tick();
        ard = 4'b1111;
        fv = 4'b0001;
        fprd[0] = 6'd7;
        cmt = 3'd1;
        #1;
        chk("drain_cnt", int'(fl_cnt), 3);
        chk("drain_stall", int'(alloc_stall), 1);
        tick();
        fv = 4'b0000;
        cmt = 3'd0;
        #1;
        chk("refill_cnt", int'(fl_cnt), 4);
        chk("refill_stall", int'(alloc_stall), 0);
        chk("refill_prd0", int'(prd[0]), 61);
        chk("refill_prd1", int'(prd[1]), 62);
        chk("refill_prd2", int'(prd[2]), 63);
        chk("refill_prd3", int'(prd[3]), 7);
        tick();
        ard = 4'b0001;
        #1;
        chk("empty_stall", int'(alloc_stall), 1);
        ard = 4'b0000;
        #1;
        chk("empty_req0_stall", int'(alloc_stall), 0);
        tick();

        // Asynchronous reset mid-operation.
        idle();
        rst = 1'b1;
        #1;
        chk("async_rst_cnt", int'(fl_cnt), 32);
        tick();
        rst = 1'b0;

        // Allocate 8, commit 2, then flush.
        alloc_vld = 1'b1;
        ard = 4'b1111;
        repeat (2) tick();
        idle();
        fv = 4'b0011;
        fprd[0] = 6'd0;
        fprd[1] = 6'd1;
        cmt = 3'd2;
        #1;
        chk("pre_cmt_cnt", int'(fl_cnt), 24);
        tick();
        idle();
        flush = 1'b1;
        #1;
        chk("pre_flush_cnt", int'(fl_cnt), 26);
        tick();
        idle();
        ard = 4'b1111;
        #1;
        chk("flush_cnt", int'(fl_cnt), 32);
        chk("flush_prd0", int'(prd[0]), 34);

        // Flush with same-cycle allocation (dropped) and free (kept).
        alloc_vld = 1'b1;
        tick();
        fv = 4'b0001;
        fprd[0] = 6'd20;
        cmt = 3'd1;
        flush = 1'b1;
        tick();
        idle();
        ard = 4'b1111;
        #1;
        chk("flush2_cnt", int'(fl_cnt), 32);
        chk("flush2_prd0", int'(prd[0]), 35);

        // Steady state: allocate 4 and free 4 per cycle through pointer wrap.
        for (int c = 0; c < 20; c++) begin
            alloc_vld = 1'b1;
            ard = 4'b1111;
            fv = 4'b1111;
            cmt = 3'd4;
            for (int k = 0; k < 4; k++) fprd[k] = 6'((c * 4 + k + 10) % 64);
            #1;
            if (c == 8) chk("wrap_reuse_prd0", int'(prd[0]), 10);
            tick();
        end
        idle();
        #1;
        chk("wrap_cnt", int'(fl_cnt), 32);

`ifdef RN_FL_OVF_CHK_EN
        // Free at full: sticky error until reset.
        fv = 4'b0001;
        fprd[0] = 6'd5;
        tick();
        idle();
        #1;
        chk("ovf_err", int'(fl_err), 1);
        repeat (3) tick();
        chk("ovf_err_held", int'(fl_err), 1);
        rst = 1'b1;
        #1;
        chk("ovf_err_rst", int'(fl_err), 0);
        tick();
        rst = 1'b0;
`endif

        idle();
        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/rn_free_list.md
Name: rn_free_list

Overview:
- Physical-register free list for the 4-wide rename stage.
- Sits directly upstream of rename stage0 and dependency checking; supplies one new physical destination (prd) per renaming instruction in program order.
- Commit returns old physical mappings to the free list.
- On flush, the allocation head rolls back to the committed head, so speculatively allocated registers are reclaimed.

Parameters:
- PREG_NUM, 64, total physical registers.
- ARCH_NUM, 32, architectural registers; pregs 0..ARCH_NUM-1 are mapped identity at reset.
- PREG_W, 6, physical register index width (log2 PREG_NUM).
- FL_DEPTH, PREG_NUM-ARCH_NUM (32), free-list entries; must be a power of two.
- PTR_W, log2(FL_DEPTH)+1 (6), pointer width; the MSB is the wrap bit.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- alloc_vld_i  in  1  a rename group is presented this cycle.
- inst0_ard_vld_i..inst3_ard_vld_i  in  1 each  instruction k writes a destination register.
- inst0_prd_o..inst3_prd_o  out  PREG_W each  physical destination offered to instruction k.
- alloc_stall_o  out  1  too few free entries for the group; the group is not consumed.
- free0_vld_i..free3_vld_i  in  1 each  commit-side release valid.
- free0_prd_i..free3_prd_i  in  PREG_W each  old physical register being released.
- cmt_num_i  in  3  count (0..4) of committing instructions that own a destination this cycle.
- flush_i  in  1  pipeline flush / misprediction recovery.
- fl_cnt_o  out  PTR_W  current number of free entries.
- fl_err_o  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Storage: FL_DEPTH x PREG_W register array. Three pointers: head (speculative alloc), cmt_head (committed alloc), tail (write).
- Reset values:
  - entry[i] = ARCH_NUM+i.
  - head = cmt_head = 0.
  - tail = FL_DEPTH (wrap bit set, index 0), so the list is full.
  - fl_cnt_o = 32, alloc_stall_o = 0, fl_err_o = 0.
- fl_cnt_o = tail - head (PTR_W-bit modular subtraction). Full: count == FL_DEPTH. Empty: count == 0.
- Request count: req = popcount(inst0..3_ard_vld_i).
- Offsets: off_k = popcount of ard_vld for instructions 0..k-1.
- inst_k_prd_o = entry[(head + off_k) mod FL_DEPTH], combinational read with zero latency in the same cycle as the request.
  - When inst_k_ard_vld_i = 0, the output is driven with the same value but is ignored downstream.
- alloc_stall_o = alloc_vld_i & (req > fl_cnt_o), combinational. Allocation is all-or-nothing; no partial group is ever consumed.
- Allocation fire = alloc_vld_i & ~alloc_stall_o & ~flush_i. On fire, head <= head + req at the clock edge. req = 0 is legal and leaves head unchanged.
- Free:
  - Valid free lanes are compacted in lane order (0 first) and written to entry[tail], entry[tail+1], ...
  - tail <= tail + popcount(free_vld).
  - Invalid lanes create no holes.
- Commit: cmt_head <= cmt_head + cmt_num_i every cycle. cmt_num_i must equal popcount(free_vld) for the same cycle.
- Frees written this cycle are not visible to allocation until the next cycle. Count and stall use the pre-edge tail.
- Simultaneous alloc + free: both pointers update in the same edge, with no conflict. The entries written are never the entries being read, because count <= FL_DEPTH always holds.
- Flush:
  - head <= cmt_head + cmt_num_i (the post-update committed head).
  - Any same-cycle allocation is dropped.
  - Same-cycle frees are still applied.
  - fl_cnt_o reflects the recovered count on the next cycle.
- Pointer wrap: pointers increment modulo 2^PTR_W; indices use the low log2(FL_DEPTH) bits.
- Reset asserted mid-operation: all pointers and entries return to their reset values immediately (asynchronous). Outputs are valid from the first clock edge after release.

Optional Feature:
- Macro: RN_FL_OVF_CHK_EN.
- Defined:
  - fl_err_o sets and stays 1 until reset when a free would make the next count exceed FL_DEPTH (overflow).
  - It also sets when cmt_head would pass head (commit of unallocated entries).
  - The offending free is still written (no corrective action).
- Undefined: fl_err_o is tied to 0 and no checking logic is generated.

Test Plan:
- Reset, then read with all ard_vld = 1 -> inst0..3_prd_o = 32, 33, 34, 35; fl_cnt_o = 32, alloc_stall_o = 0.
- Group with ard_vld = 1,0,1,1 fired -> prd for inst0/2/3 = 32/33/34; next cycle head = 3, fl_cnt_o = 29.
- Drain to count = 3, then a 4-dest group -> alloc_stall_o = 1, head unchanged. Same cycle free0_prd_i = 7 -> next cycle count = 4, stall clears, group gets the 3 old entries plus 7 last.
- Allocate 8 (count 24), commit 2 (cmt_num_i = 2, frees 0 and 1), then flush_i -> next cycle head = cmt_head = 2, fl_cnt_o = 32.
- Allocate and free 4 per cycle for 20 cycles (pointer wraps) -> fl_cnt_o stays 32; prd sequence follows FIFO order, with released registers reappearing after 32 allocations.
- With RN_FL_OVF_CHK_EN: at full, assert free0_vld_i -> fl_err_o = 1 next cycle and held until rst_i.
